// File: rtl/csr_ctrl_if.sv
// csr_ctrl_if
//   Bundles the three channels around the CSR issue/response sequencer:
//     - instruction channel from execute   (instr_valid/instr_ready, instr, rs1_data)
//     - CSR file port                      (csr_wr_en, csr_op, csr_uimm, csr_addr,
//                                            csr_data_in, csr_rdata)
//     - writeback channel                  (wb_valid/wb_ready, wb_we, wb_rd, wb_data)
//     - illegal instruction pulse
//   Modports:
//     slave  : the sequencer itself (consumes instructions, drives CSR port and writeback)
//     master : the surrounding pipeline (execute, CSR file, writeback stage)
interface csr_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;

    logic        csr_wr_en;
    logic [2:0]  csr_op;
    logic [4:0]  csr_uimm;
    logic [11:0] csr_addr;
    logic [31:0] csr_data_in;
    logic [31:0] csr_rdata;

    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        illegal;

    modport slave (
        input  instr_valid, instr, rs1_data, csr_rdata, wb_ready,
        output instr_ready, csr_wr_en, csr_op, csr_uimm, csr_addr, csr_data_in,
               wb_valid, wb_we, wb_rd, wb_data, illegal
    );

    modport master (
        output instr_valid, instr, rs1_data, csr_rdata, wb_ready,
        input  instr_ready, csr_wr_en, csr_op, csr_uimm, csr_addr, csr_data_in,
               wb_valid, wb_we, wb_rd, wb_data, illegal
    );
endinterface

// File: rtl/csr_ctrl.sv
// csr_ctrl
//   Issue/response sequencer in front of the CSR register file. Takes one
//   Zicsr instruction from execute, drives the CSR file port for one cycle,
//   captures the (one-cycle registered) old CSR value and hands it to
//   writeback over a valid/ready handshake. Illegal instructions produce a
//   one-cycle pulse on illegal and never reach the CSR file.
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : csr_ctrl_if.slave (instruction, CSR file and writeback channels)
//   Parameters:
//     PARK_ADDR : address shown on csr_addr when no access is in flight
//     RO_CHECK  : flag writes to the read-only CSR space (addr[11:10]==2'b11)
module csr_ctrl #(
    parameter logic [11:0] PARK_ADDR = 12'h000,
    parameter bit          RO_CHECK  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    csr_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [4:0]  uimm_q, uimm_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] data_q, data_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        resp_first_q, resp_first_d;
    logic        illegal_q, illegal_d;

    // ---------------------------------------------------------------------
    // Decode of the offered instruction (only meaningful in IDLE)
    // ---------------------------------------------------------------------
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [4:0]  dec_field;
    logic [11:0] dec_addr;
    logic        dec_wr_eff;
    logic        dec_illegal;
    logic        iss_wr_eff;

    always_comb begin
        dec_opcode = bus.instr[6:0];
        dec_funct3 = bus.instr[14:12];
        dec_field  = bus.instr[19:15];
        dec_addr   = bus.instr[31:20];
        // CSRRW/CSRRWI always write; set/clear forms only write with a non-zero operand field
        dec_wr_eff = (dec_funct3[1:0] == 2'b01) || (dec_field != 5'd0);
        // funct3 000 and 100 are the only SYSTEM encodings with op bits 00
        dec_illegal = (dec_opcode != OPC_SYSTEM)
                   || (dec_funct3[1:0] == 2'b00)
                   || (RO_CHECK && (dec_addr[11:10] == 2'b11) && dec_wr_eff);
    end

    assign iss_wr_eff = (funct3_q[1:0] == 2'b01) || (uimm_q != 5'd0);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= 12'd0;
            uimm_q       <= 5'd0;
            rd_q         <= 5'd0;
            funct3_q     <= 3'd0;
            data_q       <= 32'd0;
            wb_data_q    <= 32'd0;
            resp_first_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            uimm_q       <= uimm_d;
            rd_q         <= rd_d;
            funct3_q     <= funct3_d;
            data_q       <= data_d;
            wb_data_q    <= wb_data_d;
            resp_first_q <= resp_first_d;
            illegal_q    <= illegal_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath capture
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        uimm_d       = uimm_q;
        rd_d         = rd_q;
        funct3_d     = funct3_q;
        data_d       = data_q;
        wb_data_d    = wb_data_q;
        resp_first_d = 1'b0;
        illegal_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end else begin
                        addr_d   = dec_addr;
                        uimm_d   = dec_field;
                        rd_d     = bus.instr[11:7];
                        funct3_d = dec_funct3;
                        data_d   = bus.rs1_data;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                resp_first_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                // csr_rdata holds the pre-write value only during the first RESP
                // cycle; afterwards the CSR file is reading the parked address.
                if (resp_first_q) begin
                    wb_data_d = bus.csr_rdata;
                end
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        bus.instr_ready = (state_q == IDLE);
        bus.wb_valid    = (state_q == RESP);
        bus.wb_we       = (state_q == RESP) && (rd_q != 5'd0);
        bus.wb_rd       = rd_q;
        bus.wb_data     = resp_first_q ? bus.csr_rdata : wb_data_q;
        bus.illegal     = illegal_q;

        bus.csr_addr    = PARK_ADDR;
        bus.csr_op      = 3'b000;
        bus.csr_wr_en   = 1'b0;
        bus.csr_uimm    = 5'd0;
        bus.csr_data_in = 32'd0;
        if (state_q == ISSUE) begin
            bus.csr_addr    = addr_q;
            // a non-effective set/clear degrades to NOP so the CSR file only reads
            bus.csr_op      = {funct3_q[2], iss_wr_eff ? funct3_q[1:0] : 2'b00};
            bus.csr_wr_en   = iss_wr_eff;
            bus.csr_uimm    = uimm_q;
            bus.csr_data_in = data_q;
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
module tb_csr_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csr_ctrl_if bus_if ();

    csr_ctrl #(
        .PARK_ADDR(12'h000),
        .RO_CHECK (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    // ------------------------------------------------------------------
    // CSR register file model: registered read, write applied on the same
    // edge (read returns the old value).
    // ------------------------------------------------------------------
    logic [31:0] csr_mem [4096];
    logic [31:0] operand;
    initial begin
        for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
    end
    assign operand = bus_if.csr_op[2] ? {27'd0, bus_if.csr_uimm} : bus_if.csr_data_in;
    always @(posedge clk) begin
        bus_if.csr_rdata <= csr_mem[bus_if.csr_addr];
        if (bus_if.csr_wr_en) begin
            case (bus_if.csr_op[1:0])
                2'b01:   csr_mem[bus_if.csr_addr] <= operand;
                2'b10:   csr_mem[bus_if.csr_addr] <= csr_mem[bus_if.csr_addr] | operand;
                2'b11:   csr_mem[bus_if.csr_addr] <= csr_mem[bus_if.csr_addr] & ~operand;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [11:0] addr;
        logic [2:0]  op;
        logic        we;
        logic [4:0]  uimm;
        logic [31:0] din;
    } iss_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_t;

    iss_t iss_q[$];
    wb_t  wb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_illegal_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_iss(input logic [11:0] a, input logic [2:0] op, input logic we,
                            input logic [4:0] u, input logic [31:0] d);
        iss_t e;
        e.addr = a; e.op = op; e.we = we; e.uimm = u; e.din = d;
        iss_q.push_back(e);
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic we, input logic [31:0] d);
        wb_t e;
        e.rd = rd; e.we = we; e.data = d;
        wb_q.push_back(e);
    endtask

    // Monitors sample 2 time units after the falling edge, clear of stimulus updates.
    always @(negedge clk) begin
        #2;
        if (rst_n && bus_if.csr_addr != 12'h000) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_issue_addr", {20'd0, bus_if.csr_addr}, 32'h0);
            end else begin
                iss_t e;
                e = iss_q.pop_front();
                $display("issue addr=%h op=%b we=%b uimm=%h din=%h",
                         bus_if.csr_addr, bus_if.csr_op, bus_if.csr_wr_en,
                         bus_if.csr_uimm, bus_if.csr_data_in);
                chk("issue_addr", {20'd0, bus_if.csr_addr}, {20'd0, e.addr});
                chk("issue_op",   {29'd0, bus_if.csr_op},   {29'd0, e.op});
                chk("issue_we",   {31'd0, bus_if.csr_wr_en}, {31'd0, e.we});
                chk("issue_uimm", {27'd0, bus_if.csr_uimm}, {27'd0, e.uimm});
                chk("issue_din",  bus_if.csr_data_in, e.din);
            end
        end
        if (rst_n && bus_if.wb_valid && bus_if.wb_ready) begin
            if (wb_q.size() == 0) begin
                chk("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
                wb_t w;
                w = wb_q.pop_front();
                $display("wb rd=%0d we=%b data=%h", bus_if.wb_rd, bus_if.wb_we, bus_if.wb_data);
                chk("wb_rd",   {27'd0, bus_if.wb_rd}, {27'd0, w.rd});
                chk("wb_we",   {31'd0, bus_if.wb_we}, {31'd0, w.we});
                chk("wb_data", bus_if.wb_data, w.data);
            end
        end
        if (rst_n && bus_if.illegal) n_illegal_seen++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left on a falling edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] ins, input logic [31:0] rs1, input logic exp_ill);
        int n = 0;
        bus_if.instr       = ins;
        bus_if.rs1_data    = rs1;
        bus_if.instr_valid = 1'b1;
        while (!bus_if.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        chk("illegal_after_accept", {31'd0, bus_if.illegal}, {31'd0, exp_ill});
        if (exp_ill) begin
            chk("illegal_stay_idle", {31'd0, bus_if.instr_ready}, 32'd1);
            @(negedge clk);
            chk("illegal_one_cycle", {31'd0, bus_if.illegal}, 32'd0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus_if.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        bus_if.instr_valid = 1'b0;
        bus_if.instr       = 32'd0;
        bus_if.rs1_data    = 32'd0;
        bus_if.wb_ready    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_instr_ready", {31'd0, bus_if.instr_ready}, 32'd1);
        chk("rst_csr_addr",    {20'd0, bus_if.csr_addr},    32'h0);
        chk("rst_csr_wr_en",   {31'd0, bus_if.csr_wr_en},   32'd0);
        chk("rst_csr_op",      {29'd0, bus_if.csr_op},      32'd0);
        chk("rst_wb_valid",    {31'd0, bus_if.wb_valid},    32'd0);
        chk("rst_wb_data",     bus_if.wb_data,              32'd0);
        chk("rst_illegal",     {31'd0, bus_if.illegal},     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: CSRRW x5,0x309,x6
        push_iss(12'h309, 3'b001, 1'b1, 5'd6, 32'hDEADBEEF);
        push_wb(5'd5, 1'b1, 32'h00000000);
        send(32'h309312F3, 32'hDEADBEEF, 1'b0);
        chk("t1_no_wb_in_issue", {31'd0, bus_if.wb_valid}, 32'd0);
        @(negedge clk);
        chk("t1_wb_valid_n2", {31'd0, bus_if.wb_valid}, 32'd1);

        // 2: CSRRS x7,0x309,x0 -> pure read, op degrades to NOP
        push_iss(12'h309, 3'b000, 1'b0, 5'd0, 32'hFFFFFFFF);
        push_wb(5'd7, 1'b1, 32'hDEADBEEF);
        send(32'h309023F3, 32'hFFFFFFFF, 1'b0);

        // 3: CSRRCI x1,0x309,0x0F, then read back
        push_iss(12'h309, 3'b111, 1'b1, 5'h0F, 32'h00000000);
        push_wb(5'd1, 1'b1, 32'hDEADBEEF);
        send(32'h3097F0F3, 32'h00000000, 1'b0);
        push_iss(12'h309, 3'b000, 1'b0, 5'd0, 32'h00000000);
        push_wb(5'd7, 1'b1, 32'hDEADBEE0);
        send(32'h309023F3, 32'h00000000, 1'b0);
        wait_idle();

        // 4: CSRRW x0,0x309,x6 with writeback stalled and a new instruction held
        bus_if.wb_ready = 1'b0;
        push_iss(12'h309, 3'b001, 1'b1, 5'd6, 32'h00001111);
        push_wb(5'd0, 1'b0, 32'hDEADBEE0);
        send(32'h30931073, 32'h00001111, 1'b0);
        push_iss(12'h309, 3'b000, 1'b0, 5'd0, 32'h00000000);
        push_wb(5'd7, 1'b1, 32'h00001111);
        bus_if.instr       = 32'h309023F3;
        bus_if.rs1_data    = 32'h00000000;
        bus_if.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_wb_valid",    {31'd0, bus_if.wb_valid},    32'd1);
            chk("stall_wb_data",     bus_if.wb_data,              32'hDEADBEE0);
            chk("stall_instr_ready", {31'd0, bus_if.instr_ready}, 32'd0);
            chk("stall_csr_addr",    {20'd0, bus_if.csr_addr},    32'h0);
        end
        bus_if.wb_ready = 1'b1;
        send(32'h309023F3, 32'h00000000, 1'b0);

        // 5: illegal encodings, then a legal read of the read-only space
        send(32'h30904073, 32'h00000001, 1'b1);
        send(32'h309312B3, 32'h00000001, 1'b1);
        send(32'hC00312F3, 32'h00000001, 1'b1);
        push_iss(12'hC00, 3'b000, 1'b0, 5'd0, 32'h00000000);
        push_wb(5'd7, 1'b1, 32'h00000000);
        send(32'hC00023F3, 32'h00000000, 1'b0);
        wait_idle();

        // 6: reset asserted during ISSUE aborts the write
        push_iss(12'h309, 3'b001, 1'b1, 5'd6, 32'hBADBAD00);
        send(32'h309312F3, 32'hBADBAD00, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_csr_wr_en",   {31'd0, bus_if.csr_wr_en},   32'd0);
        chk("arst_csr_addr",    {20'd0, bus_if.csr_addr},    32'h0);
        chk("arst_csr_op",      {29'd0, bus_if.csr_op},      32'd0);
        chk("arst_instr_ready", {31'd0, bus_if.instr_ready}, 32'd1);
        chk("arst_wb_valid",    {31'd0, bus_if.wb_valid},    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_iss(12'h309, 3'b000, 1'b0, 5'd0, 32'h00000000);
        push_wb(5'd7, 1'b1, 32'h00001111);
        send(32'h309023F3, 32'h00000000, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("iss_queue_drained", iss_q.size(), 32'd0);
        chk("wb_queue_drained",  wb_q.size(),  32'd0);
        chk("illegal_pulses",    n_illegal_seen, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csr_ctrl.md
Name: csr_ctrl

Overview:
- Issue and response sequencer that sits directly upstream of the CSR register file.
- Accepts one SYSTEM-opcode instruction from execute and decodes the Zicsr fields.
- Drives the CSR file's address/op/data port for exactly one cycle.
- Captures the one-cycle-registered CSR read data and returns it to writeback through a valid/ready handshake.
- Flags illegal CSR instructions.

Parameters:
- PARK_ADDR, 12'h000, CSR address driven on csr_addr whenever no access is in flight.
- RO_CHECK, 1, when 1, any write to an address with csr_addr[11:10]==2'b11 is flagged illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered by execute
- instr_ready  out  1  controller can accept an instruction (high only in IDLE)
- instr  in  32  instruction word
- rs1_data  in  32  rs1 register value, sampled on acceptance
- csr_wr_en  out  1  effective-write strobe to the CSR file
- csr_op  out  3  {imm_sel, op[1:0]}; op: 00 NOP, 01 RW, 10 RS, 11 RC
- csr_uimm  out  5  zero-extended immediate (rs1 field)
- csr_addr  out  12  CSR address
- csr_data_in  out  32  latched rs1_data
- csr_rdata  in  32  CSR file read data, valid one cycle after the address is presented
- wb_valid  out  1  result available for writeback
- wb_ready  in  1  writeback accepts the result
- wb_we  out  1  wb_valid && wb_rd != 0
- wb_rd  out  5  destination register
- wb_data  out  32  old CSR value
- illegal  out  1  one-cycle pulse for an illegal instruction

Behaviour:
- Reset values: FSM=IDLE; all outputs 0 except instr_ready=1 and csr_addr=PARK_ADDR. Reset mid-access aborts it; no write occurs after rst_n deasserts.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Acceptance is instr_valid && instr_ready.
  - On acceptance, latch csr_addr=instr[31:20], uimm=instr[19:15], rd=instr[11:7], funct3=instr[14:12], rs1_data.
  - Illegal when any of the following holds: opcode!=7'b1110011; funct3 is 000 or 100; RO_CHECK && addr[11:10]==2'b11 && write effective.
  - On illegal: illegal=1 for the next cycle only, stay in IDLE, no CSR access, no writeback.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - csr_addr=latched address; csr_op=funct3; csr_uimm and csr_data_in driven.
  - Write effective = funct3[1:0]==01, or rs1/uimm field != 0. When it is not effective, force csr_op[1:0]=00 and csr_wr_en=0.
  - csr_wr_en=1 only when the write is effective.
  - Go to RESP.
- RESP:
  - Capture csr_rdata into wb_data on entry, so the old value is read before the write.
  - wb_valid=1; wb_data and wb_rd held stable until wb_ready.
  - On wb_valid && wb_ready, go to IDLE.
  - csr_addr=PARK_ADDR and csr_op=000 during RESP.
- Outside ISSUE: csr_addr=PARK_ADDR, csr_op=3'b000, csr_wr_en=0. A NOP op writes back the current value, so a parked address is never corrupted.
- Latency: acceptance at edge N, ISSUE at N+1, wb_valid from N+2. Minimum 3 cycles per instruction with wb_ready held high.
- instr_ready=0 in ISSUE and RESP. Instructions offered then are not consumed and must be held by execute.
- rd=x0: full access is performed; wb_valid=1 with wb_we=0.

Test Plan:
1. Reset then CSRRW x5,0x309,x6 (instr=0x309312F3), rs1_data=0xDEADBEEF, wb_ready=1 -> ISSUE: csr_addr=0x309, csr_op=001, csr_wr_en=1, csr_data_in=0xDEADBEEF; next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x00000000.
2. CSRRS x7,0x309,x0 after test 1 -> csr_op=000, csr_wr_en=0, wb_data=0xDEADBEEF; CSR 0x309 remains 0xDEADBEEF.
3. CSRRCI x1,0x309,uimm=0x0F after test 1 -> csr_op=111, csr_uimm=0x0F, wb_data=0xDEADBEEF; subsequent read returns 0xDEADBEE0.
4. wb_ready=0 for 4 cycles in RESP, new instr_valid held -> wb_valid and wb_data stable, instr_ready=0, no second ISSUE until the handshake completes.
5. funct3=100 and opcode=0x33 instructions, plus CSRRW to 0xC00 with RO_CHECK=1 -> illegal pulses 1 cycle each, csr_wr_en never asserted, wb_valid stays 0.
6. rst_n low during ISSUE -> outputs return to reset values asynchronously; after release, reading 0x309 shows no write from the aborted access.
